// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshake,
// multi-cycle MUL, sticky illegal-opcode halt and a retired-instruction counter.
module multicycle_control #(
  parameter int unsigned OPCODE_W   = 7,
  parameter int unsigned ALUCTL_W   = 4,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_inc,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                alu_src,
  output logic                mem_read_b,
  output logic                mem_read_w,
  output logic                mem_write_b,
  output logic                mem_write_w,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic                instr_done,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned MCNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDB  = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_LDW  = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_STB  = OPCODE_W'(18);
  localparam logic [OPCODE_W-1:0] OP_STW  = OPCODE_W'(19);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(48);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(49);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [MCNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]    retired_q;
  logic                illegal_q;
  logic                done_q;
  logic                retire;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_LDB) ||
           (op == OP_LDW) || (op == OP_STB) || (op == OP_STW) || (op == OP_BEQ) ||
           (op == OP_JUMP);
  endfunction

  function automatic logic is_load(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDB) || (op == OP_LDW);
  endfunction

  function automatic logic is_store(input logic [OPCODE_W-1:0] op);
    return (op == OP_STB) || (op == OP_STW);
  endfunction

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        if (!is_legal(opcode)) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
          if (opcode == OP_MUL) mul_cnt_d = MCNT_W'(MUL_CYCLES - 1);
        end
      end
      StExec: begin
        if (op_q == OP_MUL) begin
          if (mul_cnt_q == '0) state_d = StWb;
          else mul_cnt_d = mul_cnt_q - MCNT_W'(1);
        end else if (is_load(op_q) || is_store(op_q)) begin
          state_d = StMem;
        end else if ((op_q == OP_BEQ) || (op_q == OP_JUMP)) begin
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) state_d = is_load(op_q) ? StWb : StFetch;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  assign retire = (state_d == StFetch) &&
                  ((state_q == StExec) || (state_q == StMem) || (state_q == StWb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= '0;
      mul_cnt_q <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      done_q    <= retire;
      if (state_q == StDecode) begin
        op_q <= opcode;
        if (!is_legal(opcode)) illegal_q <= 1'b1;
      end
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are gated by rst_n so strobes drop without waiting for a clock edge.
  always_comb begin
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_inc      = 1'b0;
    alu_control = '0;
    alu_src     = 1'b0;
    mem_read_b  = 1'b0;
    mem_read_w  = 1'b0;
    mem_write_b = 1'b0;
    mem_write_w = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_write = mem_ready;
        end
        StDecode: pc_inc = 1'b1;
        StExec: begin
          case (op_q)
            OP_SUB: alu_control = ALUCTL_W'(1);
            OP_MUL: alu_control = ALUCTL_W'(2);
            OP_LDB, OP_LDW, OP_STB, OP_STW: alu_src = 1'b1;
            OP_BEQ: begin
              alu_control = ALUCTL_W'(1);
              branch      = 1'b1;
            end
            OP_JUMP: jump = 1'b1;
            default: alu_control = '0;
          endcase
        end
        StMem: begin
          alu_src     = 1'b1;
          mem_read_b  = (op_q == OP_LDB);
          mem_read_w  = (op_q == OP_LDW);
          mem_write_b = (op_q == OP_STB);
          mem_write_w = (op_q == OP_STW);
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load(op_q);
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign instr_done = done_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors with hand-computed
// expectations, plus a narrow-counter instance to exercise retired wrap-around.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;

  logic       imem_req, ir_write, pc_inc, alu_src, mem_read_b, mem_read_w;
  logic       mem_write_b, mem_write_w, mem_to_reg, reg_write, branch, jump;
  logic       instr_done, illegal;
  logic [3:0] alu_control;
  logic [15:0] retired;

  logic       w_imem_req, w_ir_write, w_pc_inc, w_alu_src, w_mem_read_b, w_mem_read_w;
  logic       w_mem_write_b, w_mem_write_w, w_mem_to_reg, w_reg_write, w_branch, w_jump;
  logic       w_instr_done, w_illegal;
  logic [3:0] w_alu_control;
  logic [1:0] w_retired;

  logic [17:0] ctl, w_ctl;
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [17:0] IMEM = 18'h1 << 17;
  localparam logic [17:0] IRW  = 18'h1 << 16;
  localparam logic [17:0] PCI  = 18'h1 << 15;
  localparam logic [17:0] ASUB = 18'h1 << 11;
  localparam logic [17:0] AMUL = 18'h2 << 11;
  localparam logic [17:0] ASRC = 18'h1 << 10;
  localparam logic [17:0] MRB  = 18'h1 << 9;
  localparam logic [17:0] MRW  = 18'h1 << 8;
  localparam logic [17:0] MWB  = 18'h1 << 7;
  localparam logic [17:0] MWW  = 18'h1 << 6;
  localparam logic [17:0] M2R  = 18'h1 << 5;
  localparam logic [17:0] RW   = 18'h1 << 4;
  localparam logic [17:0] BR   = 18'h1 << 3;
  localparam logic [17:0] JMP  = 18'h1 << 2;
  localparam logic [17:0] DONE = 18'h1 << 1;
  localparam logic [17:0] ILL  = 18'h1;
  localparam logic [17:0] F    = IMEM | IRW;
  localparam logic [17:0] FD   = IMEM | IRW | DONE;

  localparam logic [6:0] ADD = 7'd0, SUB = 7'd1, MUL = 7'd2, LDB = 7'd16, LDW = 7'd17;
  localparam logic [6:0] STB = 7'd18, STW = 7'd19, BEQ = 7'd48, JUMP = 7'd49;
  localparam logic [6:0] X   = 7'h7f;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc), .alu_control(alu_control),
    .alu_src(alu_src), .mem_read_b(mem_read_b), .mem_read_w(mem_read_w),
    .mem_write_b(mem_write_b), .mem_write_w(mem_write_w), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .branch(branch), .jump(jump), .instr_done(instr_done),
    .illegal(illegal), .retired(retired)
  );

  multicycle_control #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .imem_req(w_imem_req), .ir_write(w_ir_write), .pc_inc(w_pc_inc),
    .alu_control(w_alu_control), .alu_src(w_alu_src), .mem_read_b(w_mem_read_b),
    .mem_read_w(w_mem_read_w), .mem_write_b(w_mem_write_b), .mem_write_w(w_mem_write_w),
    .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .branch(w_branch), .jump(w_jump),
    .instr_done(w_instr_done), .illegal(w_illegal), .retired(w_retired)
  );

  assign ctl = {imem_req, ir_write, pc_inc, alu_control, alu_src, mem_read_b, mem_read_w,
                mem_write_b, mem_write_w, mem_to_reg, reg_write, branch, jump, instr_done,
                illegal};
  assign w_ctl = {w_imem_req, w_ir_write, w_pc_inc, w_alu_control, w_alu_src, w_mem_read_b,
                  w_mem_read_w, w_mem_write_b, w_mem_write_w, w_mem_to_reg, w_reg_write,
                  w_branch, w_jump, w_instr_done, w_illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample on the falling edge, advance past the rising edge.
  task automatic step(input logic rdy, input logic [6:0] op, input logic [17:0] exp,
                      input logic [15:0] ret, input string tag);
    mem_ready = rdy;
    opcode    = op;
    @(negedge clk);
    check_eq(tag, 32'(ctl), 32'(exp));
    check_eq({tag, "_ret"}, 32'(retired), 32'(ret));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b1; opcode = ADD;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ctl", 32'(ctl), 32'd0);
    check_eq("rst_ret", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD: instr_done and retired=1 in cycle 5
    step(1, ADD, F,   0, "add_f");
    step(1, ADD, PCI, 0, "add_d");
    step(1, X,   0,   0, "add_ex");
    step(1, X,   RW,  0, "add_wb");
    // MUL: four EXEC cycles
    step(1, MUL, FD,  1, "mul_f");
    step(1, MUL, PCI, 1, "mul_d");
    for (int i = 0; i < 4; i++) step(1, X, AMUL, 1, "mul_ex");
    step(1, X,   RW,  1, "mul_wb");
    // LDW with two memory wait cycles
    step(1, LDW, FD,         2, "ldw_f");
    step(1, LDW, PCI,        2, "ldw_d");
    step(1, X,   ASRC,       2, "ldw_ex");
    step(0, X,   ASRC | MRW, 2, "ldw_mem0");
    step(0, X,   ASRC | MRW, 2, "ldw_mem1");
    step(1, X,   ASRC | MRW, 2, "ldw_mem2");
    step(1, X,   RW | M2R,   2, "ldw_wb");
    // STB with a fetch wait: instr_done only in the first FETCH cycle
    step(0, STB, IMEM | DONE, 3, "stb_fwait");
    step(1, STB, F,           3, "stb_f");
    step(1, STB, PCI,         3, "stb_d");
    step(1, X,   ASRC,        3, "stb_ex");
    step(1, X,   ASRC | MWB,  3, "stb_mem");
    step(1, JUMP, FD,  4, "jmp_f");
    step(1, JUMP, PCI, 4, "jmp_d");
    step(1, X,    JMP, 4, "jmp_ex");
    step(1, BEQ, FD,        5, "beq_f");
    step(1, BEQ, PCI,       5, "beq_d");
    step(1, X,   ASUB | BR, 5, "beq_ex");
    step(1, SUB, FD,   6, "sub_f");
    step(1, SUB, PCI,  6, "sub_d");
    step(1, X,   ASUB, 6, "sub_ex");
    step(1, X,   RW,   6, "sub_wb");
    step(1, LDB, FD,         7, "ldb_f");
    step(1, LDB, PCI,        7, "ldb_d");
    step(1, X,   ASRC,       7, "ldb_ex");
    step(1, X,   ASRC | MRB, 7, "ldb_mem");
    step(1, X,   RW | M2R,   7, "ldb_wb");
    // STW interrupted by reset while waiting in MEM
    step(1, STW, FD,   8, "stw_f");
    step(1, STW, PCI,  8, "stw_d");
    step(1, X,   ASRC, 8, "stw_ex");
    mem_ready = 1'b0;
    #2;
    check_eq("stw_mem", 32'(ctl), 32'(ASRC | MWW));
    rst_n = 1'b0;
    #1;
    check_eq("stw_rst_ctl", 32'(ctl), 32'd0);
    check_eq("stw_rst_ret", 32'(retired), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    check_eq("rst_rdy_ctl", 32'(ctl), 32'd0);
    rst_n = 1'b1;
    // Illegal opcode halts; outputs stay quiet apart from illegal
    step(1, 7'd5, F,   0, "ill_f");
    step(1, 7'd5, PCI, 0, "ill_d");
    for (int i = 0; i < 10; i++) step(i[0], ADD, ILL, 0, "halt");
    rst_n = 1'b0;
    #1;
    check_eq("halt_rst_ctl", 32'(ctl), 32'd0);
    #1 rst_n = 1'b1;
    step(1, ADD, F,   0, "res_f");
    step(1, ADD, PCI, 0, "res_d");
    step(1, X,   0,   0, "res_ex");
    step(1, X,   RW,  0, "res_wb");
    for (int i = 0; i < 2; i++) begin
      step(1, JUMP, FD,  16'(i + 1), "wj_f");
      step(1, JUMP, PCI, 16'(i + 1), "wj_d");
      step(1, X,    JMP, 16'(i + 1), "wj_ex");
    end
    // Narrow counter is at its maximum; one more ADD wraps it
    check_eq("wrap_pre", 32'(w_retired), 32'd3);
    step(1, ADD, FD,  3, "wadd_f");
    step(1, ADD, PCI, 3, "wadd_d");
    step(1, X,   0,   3, "wadd_ex");
    step(1, X,   RW,  3, "wadd_wb");
    check_eq("wrap_post", 32'(w_retired), 32'd0);
    check_eq("wide_post", 32'(retired), 32'd4);
    check_eq("wrap_ctl", 32'(w_ctl), 32'(FD));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle successor to the single-cycle CPU control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with memory via mem_ready. It adds a multi-cycle MUL, an illegal-opcode halt and a retired-instruction counter. It sits between the instruction register and the datapath/memory strobes.

Parameters:
OPCODE_W, 7, opcode width (legal encodings fit in 7 bits)
ALUCTL_W, 4, width of alu_control
MUL_CYCLES, 4, EXEC cycles spent on MUL (>=1)
CNT_W, 16, width of retired counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPCODE_W  opcode field from instruction register, valid from DECODE
mem_ready  input  1  memory handshake: current imem/dmem access completes this cycle
imem_req  output  1  instruction fetch request
ir_write  output  1  IR load enable
pc_inc  output  1  PC <= PC+4
alu_control  output  ALUCTL_W  0=add, 1=sub, 2=mul
alu_src  output  1  ALU operand B = immediate
mem_read_b / mem_read_w  output  1 each  data byte/word read
mem_write_b / mem_write_w  output  1 each  data byte/word write
mem_to_reg  output  1  writeback source = memory
reg_write  output  1  register file write enable
branch  output  1  BEQ evaluate (PC load if zero)
jump  output  1  PC <= jump target
instr_done  output  1  one-cycle retire pulse
illegal  output  1  sticky illegal-opcode flag
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, async): state=FETCH, op_q=0, mul_cnt=0, retired=0, illegal=0, done_q=0. All outputs are forced 0 while rst_n=0.
- Opcodes: ADD=0, SUB=1, MUL=2, LDB=16, LDW=17, STB=18, STW=19, BEQ=48, JUMP=49. Any other value is illegal.
- op_q latches opcode at the DECODE->next edge. Outputs after DECODE decode op_q only.
- FETCH: imem_req=1. ir_write = mem_ready; this is the only Mealy output. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: pc_inc=1 for exactly one cycle. Legal opcode -> EXEC. Illegal opcode -> HALT with illegal<=1.
- EXEC, ADD/SUB: alu_control=0/1. One cycle, then WB.
- EXEC, MUL: alu_control=2. mul_cnt loads MUL_CYCLES-1 on entry and counts down. Leave to WB when mul_cnt==0, so EXEC lasts exactly MUL_CYCLES cycles.
- EXEC, loads/stores: alu_src=1, alu_control=0. One cycle, then MEM.
- EXEC, BEQ: alu_control=1, branch=1. One cycle, then FETCH (retire).
- EXEC, JUMP: jump=1. One cycle, then FETCH (retire).
- MEM: alu_src=1. LDB/LDW assert mem_read_b/mem_read_w; STB/STW assert mem_write_b/mem_write_w. Strobes are held steady until mem_ready=1. On mem_ready=1: loads -> WB, stores -> FETCH (retire).
- WB: reg_write=1 for one cycle. mem_to_reg=1 for loads, 0 for ALU ops. Then FETCH (retire).
- Retire: on every edge that enters FETCH from EXEC/MEM/WB, done_q<=1 and retired<=retired+1. retired wraps modulo 2^CNT_W. instr_done=done_q is high for exactly the first FETCH cycle after retire; it is never high after reset.
- HALT: terminal state. Every output is 0 except illegal=1. Only rst_n exits HALT.
- Nominal latency with mem_ready tied 1:
  - ADD/SUB: 4 cycles
  - MUL: 3+MUL_CYCLES cycles
  - LDB/LDW: 5 cycles
  - STB/STW: 4 cycles
  - BEQ/JUMP: 3 cycles
- Each memory-wait cycle adds one cycle.
- Never asserted: a read and a write strobe together; reg_write outside WB; jump and branch together.
- Reset mid-instruction, e.g. during MEM: strobes drop asynchronously and retired is not incremented. After release the FSM restarts in FETCH.
- Opcode changes after DECODE have no effect (op_q is held).

Test Plan:
- ADD (0), mem_ready=1 -> FETCH,DECODE,EXEC,WB. reg_write=1 only in cycle 4, alu_control=0. instr_done in cycle 5; retired=1.
- MUL (2), MUL_CYCLES=4 -> alu_control=2 for 4 consecutive EXEC cycles. reg_write in cycle 7; retired increments once.
- LDW (17), mem_ready low for 2 MEM cycles -> mem_read_w=1 held for 3 cycles, then WB with reg_write=1 and mem_to_reg=1. Total 7 cycles.
- STB (18) then JUMP (49) -> mem_write_b for one MEM cycle and no reg_write; jump=1 for one EXEC cycle. retired=2 after both.
- Opcode 5 -> illegal=1 and HALT; all outputs 0 for 10+ cycles with retired unchanged. rst_n pulse clears illegal and the FSM resumes in FETCH.
- Assert rst_n=0 mid-MEM of STW -> mem_write_w falls with no clock edge, retired unchanged. Also preload retired=2^CNT_W-1 and retire one ADD -> retired=0.
